// File: rtl/rw_sched_pkg.sv
// Shared types and default sizing for the ReWire device scheduler.
package rw_sched_pkg;

  typedef enum logic [0:0] {
    S_DEVRST,
    S_RUN
  } state_e;

  localparam int unsigned NReqDef      = 4;
  localparam int unsigned RstCyclesDef = 2;
  localparam int unsigned CntWDef      = 16;
  localparam int unsigned IdWMax       = 4;

  // Generic response record; the scheduler sizes its own id field to ID_W.
  typedef struct packed {
    logic              data;
    logic [IdWMax-1:0] id;
    logic              last;
  } resp_t;

endpackage

// File: rtl/rw_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, circularly.
module rw_rr_arbiter
  import rw_sched_pkg::*;
#(
  parameter int unsigned N_REQ = NReqDef,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      cand = ID_W'((int'(ptr_i) + i) % int'(N_REQ));
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    if (en_i && found) begin
      grant_o[idx_o] = 1'b1;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/rw_dev_scheduler.sv
// Time-multiplexes one step-enabled ReWire device among N_REQ requesters with a
// single-entry registered response and automatic device re-reset on termination.
module rw_dev_scheduler
  import rw_sched_pkg::*;
#(
  parameter int unsigned N_REQ      = NReqDef,
  parameter int unsigned ID_W       = $clog2(N_REQ),
  parameter int unsigned RST_CYCLES = RstCyclesDef,
  parameter int unsigned CNT_W      = CntWDef
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0] req_ready_o,
  output logic             dev_in_o,
  output logic             dev_step_o,
  output logic             dev_rst_o,
  input  logic             dev_out_i,
  input  logic             dev_continue_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_data_o,
  output logic [ID_W-1:0]  resp_id_o,
  output logic             resp_last_o,
  output logic [CNT_W-1:0] step_count_o
);

  localparam int unsigned RcW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef struct packed {
    logic            data;
    logic [ID_W-1:0] id;
    logic            last;
  } resp_reg_t;

  state_e           state_q, state_d;
  logic [RcW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  resp_reg_t        resp_q, resp_d;
  logic             resp_valid_q, resp_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             run_ok;
  logic             issue;
  logic [N_REQ-1:0] arb_grant;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_any;

  // run_ok excludes req_valid so the arbiter enable never depends on its own output.
  assign run_ok = (state_q == S_RUN) && (!resp_valid_q || resp_ready_i);
  assign issue  = run_ok && arb_any;

  rw_rr_arbiter #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req_i  (req_valid_i),
    .ptr_i  (rr_ptr_q),
    .en_i   (run_ok),
    .grant_o(arb_grant),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;
    cnt_d        = cnt_q;
    dev_rst_o    = 1'b0;
    dev_step_o   = 1'b0;
    dev_in_o     = 1'b0;
    req_ready_o  = '0;

    unique case (state_q)
      S_DEVRST: begin
        dev_rst_o = 1'b1;
        if (rst_cnt_q == RcW'(RST_CYCLES - 1)) begin
          state_d   = S_RUN;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RcW'(1);
        end
      end
      S_RUN: ;
      default: state_d = S_DEVRST;
    endcase

    if (issue) begin
      req_ready_o  = arb_grant;
      dev_in_o     = req_data_i[arb_idx];
      dev_step_o   = 1'b1;
      resp_valid_d = 1'b1;
      resp_d.data  = dev_out_i;
      resp_d.id    = arb_idx;
      resp_d.last  = ~dev_continue_i;
      rr_ptr_d     = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
      cnt_d        = cnt_q + CNT_W'(1);
      if (!dev_continue_i) begin
        state_d   = S_DEVRST;
        rst_cnt_d = '0;
      end
    end else if (resp_ready_i) begin
      // A pending response may drain even while the device is being re-reset.
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_DEVRST;
      rst_cnt_q    <= '0;
      rr_ptr_q     <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_q.data;
  assign resp_id_o    = resp_q.id;
  assign resp_last_o  = resp_q.last;
  assign step_count_o = cnt_q;

endmodule

// File: tb/tb_rw_dev_scheduler.sv
// Bench for rw_dev_scheduler: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the scheduling rules.
module tb_rw_dev_scheduler;

  localparam int N  = 4;
  localparam int RC = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid, req_data, req_ready;
  logic         dev_in, dev_step, dev_rst, dev_out, dev_continue;
  logic         resp_valid, resp_ready, resp_data, resp_last;
  logic [1:0]   resp_id;
  logic [15:0]  step_count;
  logic         mask, cont;

  always #5 clk = ~clk;

  // Toy device: output is the input sample xor a per-cycle mask.
  assign dev_out      = dev_in ^ mask;
  assign dev_continue = cont;

  rw_dev_scheduler #(
    .N_REQ     (N),
    .RST_CYCLES(RC),
    .CNT_W     (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready),
    .dev_in_o      (dev_in),
    .dev_step_o    (dev_step),
    .dev_rst_o     (dev_rst),
    .dev_out_i     (dev_out),
    .dev_continue_i(dev_continue),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_data_o   (resp_data),
    .resp_id_o     (resp_id),
    .resp_last_o   (resp_last),
    .step_count_o  (step_count)
  );

  int checks   = 0;
  int failures = 0;

  // Model: reset cycles remaining, rotation pointer, one pending response, step total.
  int m_rst_left, m_ptr, m_id, m_cnt;
  bit m_v, m_d, m_l;

  logic [N-1:0] s_ready;
  logic         s_rst, s_step;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rst_left = RC;
    m_ptr      = 0;
    m_v        = 1'b0;
    m_d        = 1'b0;
    m_l        = 1'b0;
    m_id       = 0;
    m_cnt      = 0;
  endtask

  function automatic int pick(input logic [N-1:0] rv);
    for (int k = 0; k < N; k++) begin
      if (rv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic check_regs();
    chk("resp_valid", 32'(resp_valid), 32'(m_v));
    if (m_v) begin
      chk("resp_data", 32'(resp_data), 32'(m_d));
      chk("resp_id",   32'(resp_id),   32'(m_id));
      chk("resp_last", 32'(resp_last), 32'(m_l));
    end
    chk("step_count", 32'(step_count), 32'(m_cnt));
  endtask

  // Called at a negedge: check registers, drive one cycle, check combinational outputs,
  // advance the model over the coming posedge.
  task automatic step(input logic [N-1:0] rv, input logic [N-1:0] rd, input logic m,
                      input logic c, input logic rr);
    bit           inrst, can;
    int           g;
    logic [N-1:0] e_ready;
    logic         e_in;
    check_regs();
    req_valid  = rv;
    req_data   = rd;
    mask       = m;
    cont       = c;
    resp_ready = rr;
    #1;
    inrst   = (m_rst_left > 0);
    g       = pick(rv);
    can     = !inrst && (g >= 0) && (!m_v || rr);
    e_ready = can ? (N'(1) << g) : '0;
    e_in    = can ? rd[g] : 1'b0;
    chk("dev_rst",   32'(dev_rst),   32'(inrst));
    chk("dev_step",  32'(dev_step),  32'(can));
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("dev_in",    32'(dev_in),    32'(e_in));
    s_ready = req_ready;
    s_rst   = dev_rst;
    s_step  = dev_step;
    if (inrst) m_rst_left--;
    if (can) begin
      m_v   = 1'b1;
      m_d   = e_in ^ m;
      m_id  = g;
      m_l   = !c;
      m_ptr = (g + 1) % N;
      m_cnt = (m_cnt + 1) % 65536;
      if (!c) m_rst_left = RC;
    end else if (rr) begin
      m_v = 1'b0;
    end
    @(negedge clk);
  endtask

  // Asserts rst between edges; the response and counter must clear without a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("async_resp_valid", 32'(resp_valid), 32'd0);
    chk("async_step_count", 32'(step_count), 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    mask       = 1'b0;
    cont       = 1'b1;
    resp_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_dev_rst",    32'(dev_rst),    32'd1);
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_step_count", 32'(step_count), 32'd0);
    rst = 1'b0;

    // Device reset phase lasts RC cycles after release, with no grants.
    for (int i = 0; i < RC; i++) begin
      step(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1);
      chk("devrst_hold", 32'(s_rst), 32'd1);
      chk("devrst_nogrant", 32'(s_ready), 32'd0);
    end

    // Single requester.
    step(4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1);
    chk("single_grant", 32'(s_ready), 32'h2);
    chk("single_id",    32'(resp_id),    32'd1);
    chk("single_data",  32'(resp_data),  32'd1);
    chk("single_last",  32'(resp_last),  32'd0);
    chk("single_count", 32'(step_count), 32'd1);

    // Fairness from a fresh pointer.
    do_reset();
    for (int i = 0; i < RC; i++) step(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 4'($urandom), 1'($urandom), 1'b1, 1'b1);
      chk("fair_id", 32'(resp_id), 32'(i % 4));
    end
    chk("fair_count", 32'(step_count), 32'd8);

    // Backpressure holds issue and response; release issues in the same cycle.
    step(4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0);
    chk("bp_nostep",  32'(s_step),     32'd0);
    chk("bp_noready", 32'(s_ready),    32'd0);
    chk("bp_hold_id", 32'(resp_id),    32'd3);
    step(4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1);
    chk("bp_resume",  32'(s_ready),    32'h1);

    // Termination then re-reset, resuming at the rotated pointer.
    step(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1);
    chk("term_last", 32'(resp_last), 32'd1);
    for (int i = 0; i < RC; i++) begin
      step(4'b1111, 4'b1111, 1'b0, 1'b1, 1'b1);
      chk("term_devrst",  32'(s_rst),   32'd1);
      chk("term_nogrant", 32'(s_ready), 32'd0);
    end
    step(4'b1111, 4'b1111, 1'b0, 1'b1, 1'b1);
    chk("term_resume", 32'(s_ready), 32'h2);

    // Randomized traffic with an async reset in the middle.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        step(4'b1111, 4'($urandom), 1'($urandom), 1'b1, 1'b0);
        do_reset();
      end
      step(4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(7) != 0),
           ($urandom_range(3) != 0));
    end
    check_regs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
